// File: rtl/pe_ctx_seq_gen_pkg.sv
// rtl/pe_ctx_seq_gen_pkg.sv - shared widths, instruction field offsets, FSM and FU encodings
package pe_ctx_seq_gen_pkg;

   localparam int PE_FU_W   = 3;
   localparam int PE_SEL_W  = 3;
   localparam int PE_XBAR_W = 6 * PE_SEL_W;
   localparam int PE_RF_W   = 3;
   localparam int PE_INST_W = PE_FU_W + PE_XBAR_W + 2 + PE_RF_W;

   // {fu_opcode, switch, c2, c1, reg_file_sel}; reg_file_sel = {we, idx[1:0]}
   localparam int RF_LSB   = 0;
   localparam int C1_BIT   = 3;
   localparam int C2_BIT   = 4;
   localparam int XBAR_LSB = 5;
   localparam int FU_LSB   = XBAR_LSB + PE_XBAR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } pe_state_t;

   typedef enum logic [2:0] {
      FU_PASS  = 3'd0,
      FU_ADD   = 3'd1,
      FU_SUB   = 3'd2,
      FU_MUL   = 3'd3,
      FU_AND   = 3'd4,
      FU_OR    = 3'd5,
      FU_XOR   = 3'd6,
      FU_PASSB = 3'd7
   } fu_op_t;

   // crossbar sources: 0 zero, 1..4 din N/S/W/E, 5 res, 6 register file, 7 zero
   localparam logic [2:0] XS_RES = 3'd5;
   localparam logic [2:0] XS_RF  = 3'd6;

endpackage

// File: rtl/pe_ctx_seq_gen_cfg_seq.sv
// rtl/pe_ctx_seq_gen_cfg_seq.sv - context buffer, sequencer FSM and inst_r; PE_PERF_CNT_EN adds run_cycles
module pe_ctx_seq_gen_cfg_seq
   import pe_ctx_seq_gen_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int INST_W = PE_INST_W,
   parameter int ITER_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [INST_W-1:0] cfg_inst,
   output logic              cfg_ready,
   input  logic              start,
   input  logic [ITER_W-1:0] iter,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic [INST_W-1:0] inst_r,
   output logic              exe_en,
   output logic [31:0]       run_cycles
);

   localparam int AW = $clog2(DEPTH);

   pe_state_t         state_q, state_d;
   logic [AW:0]       wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [ITER_W-1:0] iter_left;
   logic [INST_W-1:0] ctx_buf [DEPTH];
   logic              exe_v, drain_ph, done_q;
   logic              cfg_acc, start_go, start_nop, last_slot;

   always_comb begin
      cfg_ready = (state_q == ST_IDLE) && (wr_ptr < (AW+1)'(DEPTH));
      cfg_acc   = cfg_valid && cfg_ready;
      // a word accepted alongside start counts toward this run's length
      start_go  = (state_q == ST_IDLE) && start && ((wr_ptr != '0) || cfg_acc) && (iter != '0);
      start_nop = (state_q == ST_IDLE) && start && !start_go;
      last_slot = ({1'b0, rd_ptr} == (wr_ptr - (AW+1)'(1)));
      state_d   = state_q;
      case (state_q)
         ST_IDLE:  if (start_go) state_d = ST_RUN;
         ST_RUN:   if (!stall && last_slot && (iter_left == ITER_W'(1))) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_ph) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q || ((state_q == ST_DRAIN) && drain_ph);
   assign exe_en = exe_v && !stall;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         iter_left <= '0;
         inst_r    <= '0;
         exe_v     <= 1'b0;
         drain_ph  <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ctx_buf[i] <= '0;
      end else begin
         done_q <= start_nop;
         if (cfg_acc) begin
            ctx_buf[wr_ptr[AW-1:0]] <= cfg_inst;
            wr_ptr                  <= wr_ptr + (AW+1)'(1);
         end
         case (state_q)
            ST_IDLE: if (start_go) begin
               iter_left <= iter;
               rd_ptr    <= '0;
            end
            ST_RUN: if (!stall) begin
               inst_r <= ctx_buf[rd_ptr];
               exe_v  <= 1'b1;
               if (last_slot) begin
                  rd_ptr    <= '0;
                  iter_left <= iter_left - ITER_W'(1);
               end else begin
                  rd_ptr <= rd_ptr + AW'(1);
               end
            end
            // phase 0 retires the final instruction, phase 1 signals done
            ST_DRAIN: if (drain_ph) begin
               drain_ph <= 1'b0;
            end else if (!stall) begin
               drain_ph <= 1'b1;
               exe_v    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef PE_PERF_CNT_EN
   logic [31:0] cnt_q;
   always_ff @(posedge clk) begin
      if (!rst)                                          cnt_q <= '0;
      else if (start_go)                                 cnt_q <= '0;
      else if (busy && !stall && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
   end
   assign run_cycles = cnt_q;
`else
   assign run_cycles = '0;
`endif

endmodule

// File: rtl/pe_ctx_seq_gen.sv
// rtl/pe_ctx_seq_gen.sv - four-direction mesh PE with context sequencer; PE_PERF_CNT_EN enables run_cycles
module pe_ctx_seq_gen
   import pe_ctx_seq_gen_pkg::*;
#(
   parameter int DW     = 32,
   parameter int DEPTH  = 16,
   parameter int INST_W = PE_INST_W,
   parameter int ITER_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [INST_W-1:0] cfg_inst,
   output logic              cfg_ready,
   input  logic              start,
   input  logic [ITER_W-1:0] iter,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   input  logic [DW-1:0]     din_N,
   input  logic [DW-1:0]     din_S,
   input  logic [DW-1:0]     din_W,
   input  logic [DW-1:0]     din_E,
   output logic [DW-1:0]     dout_N,
   output logic [DW-1:0]     dout_S,
   output logic [DW-1:0]     dout_W,
   output logic [DW-1:0]     dout_E,
   output logic [31:0]       run_cycles
);

   logic [INST_W-1:0] inst_r;
   logic              exe_en;

   pe_ctx_seq_gen_cfg_seq #(.DEPTH(DEPTH), .INST_W(INST_W), .ITER_W(ITER_W)) u_seq (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_inst(cfg_inst), .cfg_ready(cfg_ready),
      .start(start), .iter(iter), .stall(stall), .busy(busy), .done(done),
      .inst_r(inst_r), .exe_en(exe_en), .run_cycles(run_cycles)
   );

   logic [DW-1:0] res, fu_out, op_a, op_b, rf_rd;
   logic [DW-1:0] rf [4];
   logic [DW-1:0] xb [6];
   logic [1:0]    rf_idx;
   logic          rf_we;
   fu_op_t        fu_op;

   assign rf_idx = inst_r[RF_LSB +: 2];
   assign rf_we  = inst_r[RF_LSB + 2];
   assign fu_op  = fu_op_t'(inst_r[FU_LSB +: PE_FU_W]);
   assign rf_rd  = rf[rf_idx];

   // 7x6 crossbar: destinations 0..3 drive the mesh, 4..5 feed the FU operand muxes
   always_comb begin
      for (int j = 0; j < 6; j++) begin
         case (inst_r[XBAR_LSB + PE_SEL_W*j +: PE_SEL_W])
            3'd1:    xb[j] = din_N;
            3'd2:    xb[j] = din_S;
            3'd3:    xb[j] = din_W;
            3'd4:    xb[j] = din_E;
            XS_RES:  xb[j] = res;
            XS_RF:   xb[j] = rf_rd;
            default: xb[j] = '0;
         endcase
      end
   end

   assign dout_N = xb[0];
   assign dout_S = xb[1];
   assign dout_W = xb[2];
   assign dout_E = xb[3];

   always_comb begin
      op_a = inst_r[C1_BIT] ? res   : xb[4];
      op_b = inst_r[C2_BIT] ? rf_rd : xb[5];
      case (fu_op)
         FU_PASS:  fu_out = op_a;
         FU_ADD:   fu_out = op_a + op_b;
         FU_SUB:   fu_out = op_a - op_b;
         FU_MUL:   fu_out = op_a * op_b;
         FU_AND:   fu_out = op_a & op_b;
         FU_OR:    fu_out = op_a | op_b;
         FU_XOR:   fu_out = op_a ^ op_b;
         default:  fu_out = op_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         res <= '0;
         for (int i = 0; i < 4; i++) rf[i] <= '0;
      end else if (exe_en) begin
         res <= fu_out;
         if (rf_we) rf[rf_idx] <= fu_out;
      end
   end

endmodule
